// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The slave modport is the loader side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Packs an MSB-first byte stream into 32-bit words and writes them
// into the instruction memory, holding the CPU while loading.
module imem_loader #(
  parameter int ADDR_W        = 10,
  parameter int DEPTH         = 1024,
  parameter bit HOLD_AT_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic [31:0]       csum_q, csum_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;

  logic [ADDR_W+1:0] end_addr;
  logic [ADDR_W:0]   ww_inc;
  logic              idle_like;

  assign end_addr  = {2'b00, start_addr} + {1'b0, word_count};
  assign ww_inc    = ww_q + 1'b1;
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE)
                  || (state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    ww_d    = ww_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    hold_d  = hold_q;

    if (idle_like && start) begin
      cnt_d  = 2'd0;
      csum_d = 32'h0;
      ww_d   = '0;
      addr_d = start_addr;
      wc_d   = word_count;
      unique case (1'b1)
        (word_count == '0): begin
          state_d = S_DONE;
          hold_d  = 1'b0;
        end
        (end_addr > DEPTH_W): begin
          state_d = S_ERR;
          hold_d  = 1'b1;
        end
        default: begin
          state_d = S_RECV;
          hold_d  = 1'b1;
        end
      endcase
    end else if (state_q == S_RECV) begin
      if (bus.byte_valid) begin
        // shifting left puts the first byte in [31:24]
        word_d = {word_q[23:0], bus.byte_data};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_WRITE;
          we_d    = 1'b1;
        end
      end
    end else if (state_q == S_WRITE) begin
      csum_d = csum_q ^ word_q;
      ww_d   = ww_inc;
      addr_d = addr_q + 1'b1;
      cnt_d  = 2'd0;
      if (ww_inc == wc_q) begin
        state_d = S_DONE;
        hold_d  = 1'b0;
      end else begin
        state_d = S_RECV;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      word_q  <= 32'h0;
      addr_q  <= '0;
      wc_q    <= '0;
      ww_q    <= '0;
      csum_q  <= 32'h0;
      we_q    <= 1'b0;
      hold_q  <= HOLD_AT_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      ww_q    <= ww_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.byte_ready = (state_q == S_RECV);
  assign bus.mem_we     = we_q;
  assign bus.mem_waddr  = addr_q;
  assign bus.mem_wdata  = word_q;
  assign busy           = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);
  assign cpu_hold       = hold_q;
  assign checksum       = csum_q;
  assign words_written  = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: packing, write timing, range
// errors, zero-length loads, mid-load reset and ignored starts.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] word_count;
  logic        cpu_hold, busy, done, error;
  logic [31:0] checksum;
  logic [10:0] words_written;

  logic        cpu_hold_h, busy_h, done_h, error_h;
  logic [31:0] checksum_h;
  logic [10:0] ww_h;

  int checks = 0;
  int errors = 0;

  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(10)) bus ();
  imem_loader_if #(.ADDR_W(10)) bus_h ();

  imem_loader #(
    .ADDR_W(10), .DEPTH(1024), .HOLD_AT_RESET(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .start_addr(start_addr), .word_count(word_count),
    .bus(bus.slave), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error), .checksum(checksum),
    .words_written(words_written)
  );

  imem_loader #(
    .ADDR_W(10), .DEPTH(1024), .HOLD_AT_RESET(1'b1)
  ) dut_h (
    .clk(clk), .rst_n(rst_n), .start(1'b0),
    .start_addr(10'd0), .word_count(11'd0),
    .bus(bus_h.slave), .cpu_hold(cpu_hold_h), .busy(busy_h),
    .done(done_h), .error(error_h), .checksum(checksum_h),
    .words_written(ww_h)
  );

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa_q.push_back(bus.mem_waddr);
      wd_q.push_back(bus.mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] a, input logic [10:0] n);
    start      = 1'b1;
    start_addr = a;
    word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [31:0] w[8], input int nb,
                            input bit tgl);
    int k = 0;
    int g = 0;
    while (k < nb && g < 400) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = w[k/4][31-8*(k%4) -: 8];
      if (bus.byte_ready) begin
        k++;
        tick();
        if (k % 4 == 0) begin
          checks++;
          if (bus.mem_we !== 1'b1 || bus.byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_cycle we=%b rdy=%b exp we=1 rdy=0",
                     bus.mem_we, bus.byte_ready);
          end
        end
        if (tgl) begin
          bus.byte_valid = 1'b0;
          tick();
        end
      end else begin
        tick();
      end
      g++;
    end
    bus.byte_valid = 1'b0;
    checks++;
    if (k != nb) begin
      errors++;
      $display("FAIL send_timeout sent=%0d exp=%0d", k, nb);
    end
  endtask

  task automatic wait_end();
    int g = 0;
    while (!(done || error) && g < 20) begin
      tick();
      g++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL end_timeout done=%b error=%b exp one set",
               done, error);
    end
  endtask

  task automatic check_writes(input logic [9:0] a0,
                              input logic [31:0] w[8], input int n);
    checks++;
    if (wa_q.size() != n) begin
      errors++;
      $display("FAIL write_count got=%0d exp=%0d", wa_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wa_q[i] !== a0 + 10'(i) || wd_q[i] !== w[i]) begin
          errors++;
          $display("FAIL write%0d got=%h:%h exp=%h:%h", i,
                   wa_q[i], wd_q[i], a0 + 10'(i), w[i]);
        end
      end
    end
  endtask

  logic [31:0] w_basic[8] = '{32'h14050005, 32'h2809000A,
                              0, 0, 0, 0, 0, 0};
  logic [31:0] w_top[8] = '{32'h00000013, 32'h00100093,
                            32'h00200113, 32'h002081B3,
                            0, 0, 0, 0};

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.byte_ready, bus.mem_we, busy, done, error, cpu_hold}
        !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=000000",
               {bus.byte_ready, bus.mem_we, busy, done, error, cpu_hold});
    end
    checks++;
    if (bus.mem_waddr !== 10'd0 || bus.mem_wdata !== 32'd0
        || checksum !== 32'd0 || words_written !== 11'd0) begin
      errors++;
      $display("FAIL reset_regs got=%h %h %h %h exp=0",
               bus.mem_waddr, bus.mem_wdata, checksum, words_written);
    end
    checks++;
    if (cpu_hold_h !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold_param got=%b exp=1", cpu_hold_h);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic(input bit tgl);
    wa_q.delete();
    wd_q.delete();
    do_start(10'd0, 11'd2);
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || bus.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_busy got=%b%b%b exp=111",
               busy, cpu_hold, bus.byte_ready);
    end
    send_bytes(w_basic, 8, tgl);
    wait_end();
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || words_written !== 11'd2
        || checksum !== 32'h3C0C000F) begin
      errors++;
      $display("FAIL load_done got=%b %b %0d %h exp=1 0 2 3c0c000f",
               done, cpu_hold, words_written, checksum);
    end
    check_writes(10'd0, w_basic, 2);
  endtask

  task automatic test_range_err();
    wa_q.delete();
    wd_q.delete();
    do_start(10'd1020, 11'd5);
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0
        || bus.byte_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL range_err got=%b%b%b%b%b exp=11000",
               error, cpu_hold, busy, bus.byte_ready, done);
    end
    bus.byte_valid = 1'b1;
    repeat (10) tick();
    bus.byte_valid = 1'b0;
    checks++;
    if (wa_q.size() != 0 || error !== 1'b1) begin
      errors++;
      $display("FAIL range_nowrite got=%0d err=%b exp=0 1",
               wa_q.size(), error);
    end
  endtask

  task automatic test_top_boundary();
    wa_q.delete();
    wd_q.delete();
    do_start(10'd1020, 11'd4);
    send_bytes(w_top, 16, 1'b0);
    wait_end();
    checks++;
    if (done !== 1'b1 || words_written !== 11'd4
        || checksum !== 32'h00108020) begin
      errors++;
      $display("FAIL top_done got=%b %0d %h exp=1 4 00108020",
               done, words_written, checksum);
    end
    check_writes(10'd1020, w_top, 4);
  endtask

  task automatic test_zero();
    wa_q.delete();
    wd_q.delete();
    do_start(10'd5, 11'd0);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0
        || checksum !== 32'd0 || words_written !== 11'd0) begin
      errors++;
      $display("FAIL zero_len got=%b%b%b %h %0d exp=100 0 0",
               done, cpu_hold, busy, checksum, words_written);
    end
    repeat (4) tick();
    checks++;
    if (wa_q.size() != 0) begin
      errors++;
      $display("FAIL zero_nowrite got=%0d exp=0", wa_q.size());
    end
  endtask

  task automatic test_reset_mid();
    wa_q.delete();
    wd_q.delete();
    do_start(10'd0, 11'd2);
    send_bytes(w_basic, 6, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.byte_ready !== 1'b0 || bus.mem_we !== 1'b0
        || words_written !== 11'd0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got=%b%b%b %0d %b exp=000 0 0",
               busy, bus.byte_ready, bus.mem_we, words_written, cpu_hold);
    end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++;
    if (wa_q.size() != 1) begin
      errors++;
      $display("FAIL mid_reset_writes got=%0d exp=1", wa_q.size());
    end
    wa_q.delete();
    wd_q.delete();
    do_start(10'd0, 11'd2);
    send_bytes(w_basic, 8, 1'b0);
    wait_end();
    check_writes(10'd0, w_basic, 2);
  endtask

  task automatic test_start_in_recv();
    wa_q.delete();
    wd_q.delete();
    do_start(10'd10, 11'd2);
    do_start(10'd500, 11'd1);
    checks++;
    if (busy !== 1'b1 || bus.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL recv_start got=%b%b exp=11", busy, bus.byte_ready);
    end
    send_bytes(w_basic, 8, 1'b0);
    wait_end();
    checks++;
    if (done !== 1'b1 || words_written !== 11'd2) begin
      errors++;
      $display("FAIL recv_start_done got=%b %0d exp=1 2",
               done, words_written);
    end
    check_writes(10'd10, w_basic, 2);
  endtask

  initial begin
    start          = 1'b0;
    start_addr     = '0;
    word_count     = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus_h.byte_valid = 1'b0;
    bus_h.byte_data  = 8'h00;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_range_err();
    test_top_boundary();
    test_zero();
    test_reset_mid();
    test_start_in_recv();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
